// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the OAM DMA controller slice.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT
    } dma_state_t;

    localparam int OAM_DMA_LEN          = 256;
    localparam int OAM_RENDER_ADDR_STEP = 4;

    // Low two bits survive because the step is a multiple of four.
    function automatic logic [7:0] render_addr_step(input logic [7:0] addr);
        return addr + 8'(OAM_RENDER_ADDR_STEP);
    endfunction

endpackage

// File: rtl/oam_port_mux.sv
// Selects which source drives the primary OAM write port: DMA during PUT, CPU otherwise.
module oam_port_mux (
    input  logic       dma_sel,
    input  logic       cpu_ce,
    input  logic [7:0] dma_oam_addr,
    input  logic [7:0] dma_oam_data,
    input  logic [7:0] cpu_oam_addr,
    input  logic [7:0] cpu_oam_data,
    input  logic       cpu_oam_we,
    output logic [7:0] oam_addr,
    output logic [7:0] oam_wdata,
    output logic       oam_we
);

    // Write data is zeroed when no write is happening so the port stays quiet.
    always_comb begin
        oam_addr  = cpu_oam_addr;
        oam_wdata = cpu_oam_we ? cpu_oam_data : 8'h00;
        oam_we    = cpu_oam_we;
        if (dma_sel) begin
            oam_addr  = dma_oam_addr;
            oam_wdata = dma_oam_data;
            oam_we    = cpu_ce;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// $4014 sprite DMA sequencer and $2003/$2004 arbiter for the primary OAM write port.
// Optional OAM_ATTR_MASK_EN clears unimplemented attribute bits [4:2] on $2004 reads.
module oam_dma_ctrl
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [7:0]  cpu_data_in,
    input  logic        oamaddr_wr,
    input  logic        oamdata_wr,
    input  logic        oamdata_rd,
    input  logic        dma_wr,
    input  logic        rendering,
    input  logic        oamaddr_clr,
    input  logic [7:0]  dma_data_in,
    input  logic [7:0]  oam_data_in,
    output logic        cpu_stall,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic [7:0]  cpu_data_out,
    output logic        dma_busy
);

    dma_state_t state;
    dma_state_t next_state;

    logic [7:0] oamaddr;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] dma_byte;
    logic       parity;

    logic       dma_put;
    logic       regs_open;
    logic       cpu_we;
    logic [7:0] rd_data;
    logic [7:0] dma_oam_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (cpu_ce) begin
            state <= next_state;
        end
    end

    // HALT occupies the cycle after the $4014 write, so an even HALT cycle means an odd start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dma_wr) next_state = HALT;
            HALT:    next_state = parity ? GET : ALIGN;
            ALIGN:   next_state = GET;
            GET:     next_state = PUT;
            PUT:     next_state = (index == 8'(OAM_DMA_LEN - 1)) ? IDLE : GET;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = 1'b0;
        dma_busy  = 1'b0;
        dma_rd    = 1'b0;
        dma_put   = 1'b0;
        case (state)
            IDLE: begin
                cpu_stall = 1'b0;
                dma_busy  = 1'b0;
            end
            HALT, ALIGN: begin
                cpu_stall = 1'b1;
                dma_busy  = 1'b1;
            end
            GET: begin
                cpu_stall = 1'b1;
                dma_busy  = 1'b1;
                dma_rd    = 1'b1;
            end
            PUT: begin
                cpu_stall = 1'b1;
                dma_busy  = 1'b1;
                dma_put   = 1'b1;
            end
            default: begin
                cpu_stall = 1'b0;
                dma_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity   <= 1'b0;
            page     <= 8'h00;
            index    <= 8'h00;
            dma_byte <= 8'h00;
        end else if (cpu_ce) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (dma_wr) begin
                        page  <= cpu_data_in;
                        index <= 8'h00;
                    end
                end
                GET:     dma_byte <= dma_data_in;
                PUT:     index    <= index + 8'd1;
                default: ;
            endcase
        end
    end

    // CPU register traffic only lands when no DMA is running or being accepted this cycle.
    assign regs_open = cpu_ce && (state == IDLE) && !dma_wr;
    assign cpu_we    = regs_open && !oamaddr_clr && !oamaddr_wr && oamdata_wr && !rendering;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oamaddr <= 8'h00;
        end else if (regs_open) begin
            if (oamaddr_clr) begin
                oamaddr <= 8'h00;
            end else if (oamaddr_wr) begin
                oamaddr <= cpu_data_in;
            end else if (oamdata_wr) begin
                oamaddr <= rendering ? render_addr_step(oamaddr) : oamaddr + 8'd1;
            end
        end
    end

    always_comb begin
        rd_data = oam_data_in;
`ifdef OAM_ATTR_MASK_EN
        if (oamaddr[1:0] == 2'd2) begin
            rd_data = oam_data_in & 8'hE3;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_data_out <= 8'h00;
        end else if (cpu_ce && (state == IDLE) && oamdata_rd) begin
            cpu_data_out <= rd_data;
        end
    end

    assign dma_oam_addr = oamaddr + index;
    assign dma_addr     = dma_rd ? {page, index} : 16'h0000;

    oam_port_mux u_port_mux (
        .dma_sel      (dma_put),
        .cpu_ce       (cpu_ce),
        .dma_oam_addr (dma_oam_addr),
        .dma_oam_data (dma_byte),
        .cpu_oam_addr (oamaddr),
        .cpu_oam_data (cpu_data_in),
        .cpu_oam_we   (cpu_we),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_we       (oam_we)
    );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl with an OAM RAM model, a CPU bus source and a reference model.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_ce = 1'b0;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        oamaddr_wr = 1'b0;
    logic        oamdata_wr = 1'b0;
    logic        oamdata_rd = 1'b0;
    logic        dma_wr = 1'b0;
    logic        rendering = 1'b0;
    logic        oamaddr_clr = 1'b0;
    logic [7:0]  dma_data_in;
    logic [7:0]  oam_data_in;
    logic        cpu_stall;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  cpu_data_out;
    logic        dma_busy;

    logic [7:0] oam_mem [256] = '{default: 8'h00};
    logic [7:0] ref_oam [256] = '{default: 8'h00};
    logic [7:0] ref_addr = 8'h00;
    logic [7:0] ref_rd = 8'h00;
    logic [7:0] src_xor = 8'h00;
    bit         model_busy = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ce_count = 0;
    int rd_ces = 0;
    int we_count = 0;
    int bad_we = 0;

    oam_dma_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_ce       (cpu_ce),
        .cpu_data_in  (cpu_data_in),
        .oamaddr_wr   (oamaddr_wr),
        .oamdata_wr   (oamdata_wr),
        .oamdata_rd   (oamdata_rd),
        .dma_wr       (dma_wr),
        .rendering    (rendering),
        .oamaddr_clr  (oamaddr_clr),
        .dma_data_in  (dma_data_in),
        .oam_data_in  (oam_data_in),
        .cpu_stall    (cpu_stall),
        .dma_rd       (dma_rd),
        .dma_addr     (dma_addr),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_we       (oam_we),
        .cpu_data_out (cpu_data_out),
        .dma_busy     (dma_busy)
    );

    always #5 clk = ~clk;

    // CPU memory: each byte is a fixed function of its address, tunable per test by src_xor.
    assign dma_data_in = dma_addr[7:0] ^ dma_addr[15:8] ^ src_xor;

    always @(posedge clk) begin
        if (oam_we) oam_mem[oam_addr] <= oam_wdata;
        oam_data_in <= oam_mem[oam_addr];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) ce_count <= 0;
        else if (cpu_ce) ce_count <= ce_count + 1;
    end

    always @(posedge clk) begin
        if (cpu_ce && dma_rd) rd_ces <= rd_ces + 1;
        if (oam_we) we_count <= we_count + 1;
        if (oam_we && !cpu_ce) bad_we <= bad_we + 1;
    end

    function automatic logic [7:0] expRead(input logic [7:0] addr, input logic [7:0] raw);
`ifdef OAM_ATTR_MASK_EN
        if (addr[1:0] == 2'd2) return raw & ~8'h1C;
`endif
        return raw;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: strobes held for a few clk, then a single cpu_ce pulse; model advances with it.
    task automatic applyStimulus(input logic [7:0] data, input logic a_wr, input logic d_wr,
                                 input logic d_rd, input logic dm_wr, input logic rend,
                                 input logic clr);
        int gap;
        gap = $urandom_range(1, 2);
        @(negedge clk);
        cpu_data_in = data;
        oamaddr_wr  = a_wr;
        oamdata_wr  = d_wr;
        oamdata_rd  = d_rd;
        dma_wr      = dm_wr;
        rendering   = rend;
        oamaddr_clr = clr;
        repeat (gap) @(negedge clk);
        cpu_ce = 1'b1;
        @(negedge clk);
        cpu_ce      = 1'b0;
        oamaddr_wr  = 1'b0;
        oamdata_wr  = 1'b0;
        oamdata_rd  = 1'b0;
        dma_wr      = 1'b0;
        rendering   = 1'b0;
        oamaddr_clr = 1'b0;
        if (!model_busy && !dm_wr) begin
            if (d_rd) ref_rd = expRead(ref_addr, ref_oam[ref_addr]);
            if (clr) ref_addr = 8'h00;
            else if (a_wr) ref_addr = data;
            else if (d_wr) begin
                if (rend) ref_addr = ref_addr + 8'd4;
                else begin
                    ref_oam[ref_addr] = data;
                    ref_addr = ref_addr + 8'd1;
                end
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_oamaddr"}, 16'(oam_addr), 16'(ref_addr));
        checkOutput({tag, "_rdata"}, 16'(cpu_data_out), 16'(ref_rd));
    endtask

    task automatic compareOam(input string tag);
        for (int i = 0; i < 256; i++)
            checkOutput($sformatf("%s[%0d]", tag, i), 16'(oam_mem[i]), 16'(ref_oam[i]));
    endtask

    // Full DMA with random CPU-side noise while stalled; the noise must have no effect.
    task automatic runDma(input logic [7:0] page, input logic [7:0] xr, input bit want_odd);
        logic [7:0] base;
        int stalled;
        int first_rd;
        int rd0;
        int we0;
        if ((ce_count % 2 == 1) != want_odd) idleCycle();
        base    = ref_addr;
        src_xor = xr;
        rd0     = rd_ces;
        we0     = we_count;
        applyStimulus(page, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        model_busy = 1'b1;
        checkOutput("stall_on", 16'(cpu_stall), 16'd1);
        checkOutput("busy_on", 16'(dma_busy), 16'd1);
        stalled  = 0;
        first_rd = 0;
        while (cpu_stall && stalled < 600) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom));
            stalled++;
            if (first_rd == 0 && rd_ces != rd0) first_rd = stalled;
        end
        model_busy = 1'b0;
        for (int i = 0; i < 256; i++)
            ref_oam[8'(base + 8'(i))] = 8'(i) ^ page ^ xr;
        checkOutput("stall_cycles", 16'(stalled), 16'(513 + int'(want_odd)));
        checkOutput("first_get", 16'(first_rd), 16'(2 + int'(want_odd)));
        checkOutput("get_count", 16'(rd_ces - rd0), 16'd256);
        checkOutput("put_count", 16'(we_count - we0), 16'd256);
        checkOutput("busy_off", 16'(dma_busy), 16'd0);
        checkRegs("dma_end");
    endtask

    initial begin
        int op;
        int we0;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        checkOutput("rst_stall", 16'(cpu_stall), 16'd0);
        checkOutput("rst_busy", 16'(dma_busy), 16'd0);
        checkOutput("rst_dma_rd", 16'(dma_rd), 16'd0);
        checkOutput("rst_dma_addr", dma_addr, 16'd0);
        checkOutput("rst_oam_addr", 16'(oam_addr), 16'd0);
        checkOutput("rst_oam_wdata", 16'(oam_wdata), 16'd0);
        checkOutput("rst_oam_we", 16'(oam_we), 16'd0);
        checkOutput("rst_rdata", 16'(cpu_data_out), 16'd0);
        reset = 1'b1;

        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_0x10", 16'(oam_mem[8'h10]), 16'h00AA);
        checkOutput("wr_0x11", 16'(oam_mem[8'h11]), 16'h00BB);
        checkOutput("addr_0x12", 16'(oam_addr), 16'h0012);

        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runDma(8'h02, 8'h02, 1'b0);
        checkOutput("dma_even_0x10", 16'(oam_mem[8'h10]), 16'h0010);
        checkOutput("dma_even_0xFF", 16'(oam_mem[8'hFF]), 16'h00FF);
        compareOam("dma_even");

        runDma(8'h02, 8'h02, 1'b1);
        compareOam("dma_odd");

        applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runDma(8'h03, 8'h03, 1'b0);
        checkOutput("wrap_oam0", 16'(oam_mem[8'h00]), 16'h0010);
        checkOutput("wrap_addr", 16'(oam_addr), 16'h00F0);

        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        we0 = we_count;
        applyStimulus(8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("render_no_we", 16'(we_count - we0), 16'd0);
        checkOutput("render_addr", 16'(oam_addr), 16'h0009);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_addr", 16'(oam_addr), 16'h0000);

        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef OAM_ATTR_MASK_EN
        checkOutput("attr_read", 16'(cpu_data_out), 16'h00E3);
`else
        checkOutput("attr_read", 16'(cpu_data_out), 16'h00FF);
`endif
        checkRegs("attr");

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 4));
            d  = 8'($urandom);
            we0 = we_count;
            case (op)
                0: applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                1: applyStimulus(d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                2: applyStimulus(d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                3: applyStimulus(d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                default: applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            endcase
            checkRegs("rand");
            checkOutput("rand_we", 16'(we_count - we0), 16'(op == 1));
        end
        compareOam("rand_regs");

        for (int n = 0; n < 2; n++) begin
            applyStimulus(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            runDma(8'($urandom), 8'($urandom), 1'($urandom));
            compareOam("rand_dma");
        end

        if (ce_count % 2 == 1) idleCycle();
        applyStimulus(8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        model_busy = 1'b1;
        repeat (100) idleCycle();
        checkOutput("mid_dma_stall", 16'(cpu_stall), 16'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_stall", 16'(cpu_stall), 16'd0);
        checkOutput("rst_mid_busy", 16'(dma_busy), 16'd0);
        checkOutput("rst_mid_dma_rd", 16'(dma_rd), 16'd0);
        checkOutput("rst_mid_oam_addr", 16'(oam_addr), 16'd0);
        @(negedge clk);
        reset      = 1'b1;
        model_busy = 1'b0;
        ref_addr   = 8'h00;
        ref_rd     = 8'h00;
        applyStimulus(8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_wr", 16'(oam_mem[8'h30]), 16'h005A);
        checkRegs("post_rst");
        checkOutput("we_with_ce", 16'(bad_we), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
